// File: rtl/azadi_spi_pkg.sv
// Shared types and constants for the azadi SPI target endpoint.
package azadi_spi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2
  } spi_tgt_state_e;

  // Word sent on MISO when the master clocks a word with nothing queued.
  localparam int unsigned SpiMaxWidth = 32;
  localparam logic [SpiMaxWidth-1:0] SpiIdleFill = '1;

endpackage

// File: rtl/azadi_spi_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin with edge strobes.
module azadi_spi_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic [SyncStages:0]   primed_q;
  logic                  primed;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= {SyncStages{ResetVal}};
      prev_q   <= ResetVal;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SyncStages-2:0], d_i};
      prev_q   <= sync_q[SyncStages-1];
      primed_q <= {primed_q[SyncStages-1:0], 1'b1};
    end
  end

  // Edges stay masked until the chain holds real pin samples, so a pin that
  // differs from ResetVal when reset releases is not reported as an edge.
  assign primed = primed_q[SyncStages];
  assign q_o    = sync_q[SyncStages-1];
  assign rise_o = primed & q_o & ~prev_q;
  assign fall_o = primed & ~q_o & prev_q;

endmodule

// File: rtl/azadi_spi_target.sv
// SPI mode-0 target: oversampled pins, byte stream out with a pulse, and a
// one-entry transmit holding register in front of the MISO shifter.
module azadi_spi_target
  import azadi_spi_pkg::*;
#(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sclk_i,
  input  logic                 ss_ni,
  input  logic                 sd_i,
  output logic                 sd_o,
  output logic                 sd_oe,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_underrun_o,
  output logic                 frame_end_o
);

  localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);
  localparam logic [DataWidth-1:0] IdleWord = SpiIdleFill[DataWidth-1:0];

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, sd_sync;
  logic unused_sclk_lvl, unused_ss_lvl, unused_sd_rise, unused_sd_fall;

  azadi_spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .q_o    (unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  azadi_spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_ss (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ss_ni),
    .q_o    (unused_ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  azadi_spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sd_i),
    .q_o    (sd_sync),
    .rise_o (unused_sd_rise),
    .fall_o (unused_sd_fall)
  );

  spi_tgt_state_e      state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DataWidth-1:0] rx_shift_q, rx_shift_d;
  logic [DataWidth-1:0] tx_shift_q, tx_shift_d;
  logic [DataWidth-1:0] rx_data_q, rx_data_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 reload_q, reload_d;
  logic                 word_done_q, word_done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 underrun_q, underrun_d;
  logic                 frame_end_q, frame_end_d;
  logic                 sd_oe_q, sd_oe_d;
  logic                 consume, tx_write;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= IdleWord;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      reload_q    <= 1'b0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
      sd_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      reload_q    <= reload_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_end_q <= frame_end_d;
      sd_oe_q     <= sd_oe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    reload_d    = reload_q;
    word_done_d = 1'b0;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_end_d = 1'b0;
    sd_oe_d     = sd_oe_q;
    consume     = 1'b0;

    // A completed word is published one cycle after its last bit lands.
    if (word_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        sd_oe_d    = 1'b0;
        bit_cnt_d  = '0;
        rx_shift_d = '0;
        tx_shift_d = IdleWord;
        reload_d   = 1'b0;
        if (ss_fall) state_d = StLoad;
      end
      StLoad: begin
        consume = 1'b1;
        sd_oe_d = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        // Deselect takes priority over any sclk edge seen in the same cycle.
        if (ss_rise) begin
          state_d     = StIdle;
          sd_oe_d     = 1'b0;
          frame_end_d = 1'b1;
          bit_cnt_d   = '0;
          rx_shift_d  = '0;
          tx_shift_d  = IdleWord;
          reload_d    = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DataWidth-2:0], sd_sync};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d   = '0;
              reload_d    = 1'b1;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              consume  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DataWidth-2:0], 1'b1};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The consume looks at the holding register as it was before this cycle,
    // so a same-cycle write still counts as an underrun.
    if (consume) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = IdleWord;
        underrun_d = 1'b1;
      end
    end
  end

  assign tx_write    = tx_valid_i & ~hold_full_q;
  assign hold_full_d = (hold_full_q & ~consume) | tx_write;
  assign hold_d      = tx_write ? tx_data_i : hold_q;

  assign sd_o          = tx_shift_q[DataWidth-1];
  assign sd_oe         = sd_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;
  assign frame_end_o   = frame_end_q;

endmodule

// File: tb/tb_azadi_spi_target.sv
// Randomized bench for azadi_spi_target: a bit-banged SPI master plus a
// word-level model of the holding register feeding a scoreboard.
module tb_azadi_spi_target;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni, sclk_i, ss_ni, sd_i, sd_o, sd_oe;
  logic [DW-1:0] rx_data_o, tx_data_i;
  logic          rx_valid_o, tx_valid_i, tx_ready_o, tx_underrun_o, frame_end_o;

  always #5 clk_i = ~clk_i;

  azadi_spi_target #(.DataWidth(DW), .SyncStages(SS)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sclk_i        (sclk_i),
    .ss_ni         (ss_ni),
    .sd_i          (sd_i),
    .sd_o          (sd_o),
    .sd_oe         (sd_oe),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .tx_underrun_o (tx_underrun_o),
    .frame_end_o   (frame_end_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_unr = 0;
  int cnt_fe = 0;
  int exp_unr, exp_fe, unr0, fe0;
  int half;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  bit         m_full;
  logic [7:0] m_val;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Model: each word start takes the queued word if present, else all-ones.
  function automatic void m_consume();
    if (m_full) begin
      exp_tx.push_back(m_val);
      m_full = 1'b0;
    end else begin
      exp_tx.push_back(8'hFF);
      exp_unr++;
    end
  endfunction

  always @(negedge clk_i) begin
    if (rx_valid_o === 1'b1) begin
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_unexpected: got 0x%0h, no word expected", rx_data_o);
      end else begin
        check("rx_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
      end
    end
    if (tx_underrun_o === 1'b1) cnt_unr++;
    if (frame_end_o === 1'b1) cnt_fe++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic tx_write(input logic [7:0] v);
    tx_data_i  = v;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    m_full = 1'b1;
    m_val  = v;
  endtask

  task automatic preload(input logic [7:0] v);
    check("tx_ready_pre", 32'(tx_ready_o), 32'(!m_full));
    if (!m_full) tx_write(v);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_sd_o"}, 32'(sd_o), 32'd1);
    check({pfx, "_sd_oe"}, 32'(sd_oe), 32'd0);
    check({pfx, "_rx_data"}, 32'(rx_data_o), 32'd0);
    check({pfx, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
    check({pfx, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
    check({pfx, "_underrun"}, 32'(tx_underrun_o), 32'd0);
    check({pfx, "_frame_end"}, 32'(frame_end_o), 32'd0);
  endtask

  // Clocks nbits of one word; the master samples MISO just before each rise.
  task automatic spi_word(input logic [7:0] mosi, input int nbits, input bit wr, input logic [7:0] wv);
    logic [7:0] exp_m, got, mask;
    if (exp_tx.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL miso_model: got a word start, expected none");
      exp_m = 8'hFF;
    end else begin
      exp_m = exp_tx.pop_front();
    end
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sd_i = mosi[7-i];
      if (i == 3) begin
        check("tx_ready", 32'(tx_ready_o), 32'(!m_full));
        if (wr && !m_full) begin
          tx_write(wv);
          wait_n(half - 1);
        end else begin
          wait_n(half);
        end
      end else begin
        wait_n(half);
      end
      got[7-i] = sd_o;
      if (i == 7) exp_rx.push_back(mosi);
      sclk_i = 1'b1;
      wait_n(half);
      sclk_i = 1'b0;
    end
    mask = 8'(8'hFF << (8 - nbits));
    check("miso", 32'(got & mask), 32'(exp_m & mask));
    if (nbits == 8) m_consume();
  endtask

  // Write landing in exactly the cycle the word-boundary reload happens.
  task automatic boundary_write(input logic [7:0] v);
    wait_n(SS);
    check("tx_ready_bnd", 32'(tx_ready_o), 32'(!m_full));
    tx_write(v);
  endtask

  task automatic frame_begin();
    ss_ni = 1'b0;
    m_consume();
    wait_n(SS + 2);
    check("sd_oe_select", 32'(sd_oe), 32'd1);
  endtask

  task automatic frame_finish();
    wait_n(half);
    ss_ni = 1'b1;
    exp_fe++;
    exp_tx.delete();
    wait_n(SS + 3);
    check("sd_oe_deselect", 32'(sd_oe), 32'd0);
  endtask

  task automatic t_start();
    unr0 = cnt_unr;
    fe0 = cnt_fe;
    exp_unr = 0;
    exp_fe = 0;
  endtask

  task automatic t_end(input string nm);
    wait_n(8);
    check({nm, "_underruns"}, 32'(cnt_unr - unr0), 32'(exp_unr));
    check({nm, "_frame_ends"}, 32'(cnt_fe - fe0), 32'(exp_fe));
    check({nm, "_rx_drained"}, 32'(exp_rx.size()), 32'd0);
    exp_rx.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    sclk_i = 1'b0;
    ss_ni = 1'b1;
    sd_i = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i = '0;
    m_full = 1'b0;
    m_val = '0;
    half = 6;
    wait_n(3);
    check_reset("reset");
    rst_ni = 1'b1;
    wait_n(SS + 3);

    // Single word with a preloaded reply.
    t_start();
    preload(8'hA5);
    frame_begin();
    spi_word(8'h3C, 8, 1'b0, 8'h00);
    frame_finish();
    t_end("single");

    // Three words, refilled each time the holding register frees up.
    t_start();
    preload(8'h11);
    frame_begin();
    spi_word(8'h01, 8, 1'b1, 8'h22);
    spi_word(8'h02, 8, 1'b1, 8'h33);
    spi_word(8'h03, 8, 1'b1, 8'h44);
    frame_finish();
    t_end("three");

    // Nothing ever queued: all-ones and an underrun at every word start.
    t_start();
    frame_begin();
    for (int k = 0; k < 3; k++) spi_word(8'($urandom), 8, 1'b0, 8'h00);
    frame_finish();
    t_end("starved");

    // Deselect after five bits; a word queued mid-word survives it.
    t_start();
    preload(8'h5A);
    frame_begin();
    spi_word(8'($urandom), 5, 1'b1, 8'hC3);
    frame_finish();
    frame_begin();
    spi_word(8'($urandom), 8, 1'b0, 8'h00);
    frame_finish();
    t_end("partial");

    // Reset mid-word: outputs clear and the rest of that frame is ignored.
    t_start();
    preload(8'h77);
    frame_begin();
    spi_word(8'hB6, 3, 1'b0, 8'h00);
    rst_ni = 1'b0;
    wait_n(1);
    check_reset("midrst");
    rst_ni = 1'b1;
    m_full = 1'b0;
    exp_tx.delete();
    for (int i = 0; i < 5; i++) begin
      sd_i = 1'($urandom);
      wait_n(half);
      sclk_i = 1'b1;
      wait_n(half);
      sclk_i = 1'b0;
    end
    check("sd_oe_after_rst", 32'(sd_oe), 32'd0);
    wait_n(half);
    ss_ni = 1'b1;
    wait_n(SS + 3);
    frame_begin();
    spi_word(8'h9E, 8, 1'b0, 8'h00);
    frame_finish();
    t_end("reset_frame");

    // Fastest sclk; write coincides with the boundary reload.
    half = SS + 2;
    t_start();
    frame_begin();
    spi_word(8'($urandom), 8, 1'b0, 8'h00);
    boundary_write(8'h9C);
    spi_word(8'($urandom), 8, 1'b0, 8'h00);
    spi_word(8'($urandom), 8, 1'b0, 8'h00);
    frame_finish();
    t_end("fast_collide");

    // Random frames: lengths, refills, truncated last words and sclk rates.
    t_start();
    for (int f = 0; f < 25; f++) begin
      int nw;
      int last_bits;
      half = $urandom_range(SS + 2, SS + 5);
      nw = $urandom_range(1, 3);
      last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
      if ($urandom_range(0, 1) == 1) preload(8'($urandom));
      frame_begin();
      for (int k = 0; k < nw; k++) begin
        spi_word(8'($urandom), (k == nw - 1) ? last_bits : 8,
                 1'($urandom_range(0, 1)), 8'($urandom));
      end
      frame_finish();
    end
    t_end("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
